// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and widths for the FIFO burst reader.
package fifo_burst_reader_pkg;

  localparam int DW_DEF = 8;   // default data width, matches fifo_mem
  localparam int CNT_W  = 8;   // idle / burst counters (TIMEOUT, BURST_MAX <= 255)
  localparam int POP_W  = 16;  // total pop counter

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    COOL  = 2'd2
  } state_e;

endpackage

// File: rtl/fifo_burst_reader_if.sv
// FIFO read side plus downstream valid/ready stream and status of the burst reader.
interface fifo_burst_reader_if
  import fifo_burst_reader_pkg::*;
#(
  parameter int DW = DW_DEF
) ();

  logic [DW-1:0]    fifo_data;
  logic             fifo_empty;
  logic             fifo_threshold;
  logic             fifo_underflow;
  logic             fifo_rd;
  logic [DW-1:0]    m_data;
  logic             m_valid;
  logic             m_ready;
  logic             busy;
  logic             err_underflow;
  logic [POP_W-1:0] pop_count;

  // Reader side
  modport master (
    input  fifo_data, fifo_empty, fifo_threshold, fifo_underflow, m_ready,
    output fifo_rd, m_data, m_valid, busy, err_underflow, pop_count
  );

  // FIFO / consumer side
  modport slave (
    output fifo_data, fifo_empty, fifo_threshold, fifo_underflow, m_ready,
    input  fifo_rd, m_data, m_valid, busy, err_underflow, pop_count
  );

endinterface

// File: rtl/fifo_burst_skid.sv
// 2-entry in-order output buffer: head register feeds the stream, tail holds
// the second word while the consumer stalls.
module fifo_burst_skid #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] dout,
  output logic [1:0]    occ
);

  logic [DW-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]    occ_q, occ_d;
  logic          pop;

  assign pop   = (occ_q != 2'd0) && ready;
  assign valid = (occ_q != 2'd0);
  assign dout  = head_q;
  assign occ   = occ_q;

  // Next buffer contents for every push/pop combination
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({push, pop})
      2'b10: begin
        // a push into a full buffer is never issued by the reader; ignore it
        if (occ_q == 2'd0) begin
          head_d = din;
          occ_d  = 2'd1;
        end else if (occ_q == 2'd1) begin
          tail_d = din;
          occ_d  = 2'd2;
        end
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // occupancy unchanged; the new word lands behind whatever remains
        if (occ_q == 2'd1) begin
          head_d = din;
        end else begin
          head_d = tail_q;
          tail_d = din;
        end
      end
      default: ;
    endcase
  end

  // Buffer registers; reset discards contents
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst read controller for fifo_mem: pops on threshold or idle timeout and
// re-presents words on a valid/ready stream through a 2-entry buffer.
// Optional macro FIFO_BURST_READER_STATS_EN enables the live pop_count counter.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int BURST_MAX = 8,
  parameter int TIMEOUT   = 16
) (
  input logic                 clk,
  input logic                 rst,
  fifo_burst_reader_if.master bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             err_q, err_d;
  logic [1:0]       occ;
  logic             rd;

  // Pop only when draining, data is present and the buffer has room
  assign rd = !rst && (state_q == DRAIN) && !bus.fifo_empty && (occ < 2'd2);

  assign bus.fifo_rd       = rd;
  assign bus.busy          = (state_q != IDLE) || (occ != 2'd0);
  assign bus.err_underflow = err_q;

  // Next state and counters
  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = '0;
    burst_cnt_d = burst_cnt_q;
    err_d       = err_q | bus.fifo_underflow;
    case (state_q)
      IDLE: begin
        if (bus.fifo_threshold ||
            (!bus.fifo_empty && idle_cnt_q == CNT_W'(TIMEOUT - 1))) begin
          state_d     = DRAIN;
          burst_cnt_d = '0;
        end else if (!bus.fifo_empty) begin
          idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (rd) burst_cnt_d = burst_cnt_q + CNT_W'(1);
        if ((rd && burst_cnt_q == CNT_W'(BURST_MAX - 1)) || bus.fifo_empty)
          state_d = COOL;
      end
      // one cycle for the FIFO's registered flags to catch up
      COOL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idle_cnt_q  <= '0;
      burst_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      err_q       <= err_d;
    end
  end

`ifdef FIFO_BURST_READER_STATS_EN
  logic [POP_W-1:0] pop_cnt_q, pop_cnt_d;

  // Free-running pop total, wraps naturally
  always_comb pop_cnt_d = pop_cnt_q + POP_W'(rd);

  // Pop counter register
  always_ff @(posedge clk) begin
    if (rst) pop_cnt_q <= '0;
    else     pop_cnt_q <= pop_cnt_d;
  end

  assign bus.pop_count = pop_cnt_q;
`else
  assign bus.pop_count = '0;
`endif

  fifo_burst_skid #(.DW(DW)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (rd),
    .din   (bus.fifo_data),
    .ready (bus.m_ready),
    .valid (bus.m_valid),
    .dout  (bus.m_data),
    .occ   (occ)
  );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural fifo_mem model
// (combinational read, threshold at 8 words) and an in-order scoreboard.
module tb_fifo_burst_reader;
  import fifo_burst_reader_pkg::*;

  localparam int TIMEOUT = 16;

  logic clk;
  logic rst;

  fifo_burst_reader_if #(.DW(8)) ifc ();

  fifo_burst_reader #(.DW(8), .BURST_MAX(8), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rdy;
    logic       rd;
    logic       vld;
    logic [7:0] dat;
    logic       bsy;
  } vec_t;

  vec_t       tbl [12];
  logic [7:0] fq   [$];
  logic [7:0] expq [$];
  int         bursts [$];
  int         checks, failures;
  int         total_pops, sc_pops;
  logic       prev_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_flags();
    ifc.fifo_empty     = (fq.size() == 0);
    ifc.fifo_data      = (fq.size() != 0) ? fq[0] : 8'h00;
    ifc.fifo_threshold = (fq.size() >= 8);
  endtask

  task automatic write_words(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) fq.push_back(base + 8'(i));
    drive_flags();
  endtask

  // One clock: called and returns at a negedge
  task automatic tick();
    logic rd;
    rd = ifc.fifo_rd;
    if (ifc.m_valid && ifc.m_ready) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_extra: got %0h expected no word (t=%0t)", ifc.m_data, $time);
      end else begin
        chk("sb_data", {24'h0, ifc.m_data}, {24'h0, expq.pop_front()});
      end
    end
    if (rd) begin
      if (fq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_on_empty: got 1 expected 0 (t=%0t)", $time);
      end else begin
        expq.push_back(fq[0]);
      end
      total_pops++;
      sc_pops++;
      if (!prev_rd) bursts.push_back(1);
      else if (bursts.size() != 0) bursts[bursts.size()-1]++;
    end
    prev_rd = rd;
    @(posedge clk);
    #1;
    if (rd && fq.size() != 0) void'(fq.pop_front());
    drive_flags();
    @(negedge clk);
  endtask

  task automatic run_until_idle(input int max);
    int n;
    n = 0;
    while ((fq.size() != 0 || ifc.busy) && n < max) begin
      tick();
      n++;
    end
    if (n >= max) begin
      checks++;
      failures++;
      $display("FAIL idle_wait: got still busy expected idle within %0d cycles", max);
    end
    chk("sb_leftover", expq.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    logic [31:0] exp_pc;
    checks = 0; failures = 0; total_pops = 0; sc_pops = 0; prev_rd = 1'b0;
    rst = 1'b1;
    ifc.m_ready = 1'b1;
    ifc.fifo_underflow = 1'b0;
    drive_flags();

    // burst of 8 on threshold, consumer always ready; row i = cycle i after the write
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 8'h01, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 8'h02, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 8'h03, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 8'h04, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 8'h05, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 8'h06, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 8'h07, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 8'h08, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0};

    @(negedge clk);
    @(negedge clk);
    chk("rst_m_valid", ifc.m_valid, 0);
    chk("rst_m_data", ifc.m_data, 0);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_fifo_rd", ifc.fifo_rd, 0);
    chk("rst_err", ifc.err_underflow, 0);
    chk("rst_pop_count", ifc.pop_count, 0);
    rst = 1'b0;

    // Scenario 1: threshold burst, table driven
    write_words(8'h01, 8);
    for (int i = 0; i < 12; i++) begin
      ifc.m_ready = tbl[i].rdy;
      chk($sformatf("s1_rd[%0d]", i), ifc.fifo_rd, tbl[i].rd);
      chk($sformatf("s1_vld[%0d]", i), ifc.m_valid, tbl[i].vld);
      chk($sformatf("s1_busy[%0d]", i), ifc.busy, tbl[i].bsy);
      if (tbl[i].vld) chk($sformatf("s1_data[%0d]", i), ifc.m_data, tbl[i].dat);
      tick();
    end
    run_until_idle(50);

    // Scenario 2: 3 words below threshold drain on timeout
    sc_pops = 0;
    write_words(8'h11, 3);
    k = 0;
    while (!ifc.fifo_rd && k < 100) begin
      tick();
      k++;
    end
    chk("s2_timeout_latency", k, TIMEOUT);
    run_until_idle(50);
    chk("s2_pops", sc_pops, 3);

    // Scenario 3: 17 words -> bursts 8, 8, 1
    sc_pops = 0;
    bursts.delete();
    write_words(8'h20, 17);
    run_until_idle(200);
    chk("s3_pops", sc_pops, 17);
    chk("s3_nbursts", bursts.size(), 3);
    if (bursts.size() == 3) begin
      chk("s3_burst0", bursts[0], 8);
      chk("s3_burst1", bursts[1], 8);
      chk("s3_burst2", bursts[2], 1);
    end
`ifdef FIFO_BURST_READER_STATS_EN
    exp_pc = 32'd28;
`else
    exp_pc = 32'd0;
`endif
    chk("s3_pop_count", ifc.pop_count, exp_pc);

    // Scenario 4: consumer stalls mid-burst
    sc_pops = 0;
    ifc.m_ready = 1'b0;
    write_words(8'h40, 8);
    for (int i = 0; i < 8; i++) tick();
    chk("s4_stall_pops", sc_pops, 2);
    chk("s4_stall_vld", ifc.m_valid, 1);
    chk("s4_stall_data", ifc.m_data, 8'h40);
    chk("s4_stall_rd", ifc.fifo_rd, 0);
    ifc.m_ready = 1'b1;
    run_until_idle(100);
    chk("s4_pops", sc_pops, 8);

    // Scenario 5: reset with both buffer entries full
    sc_pops = 0;
    ifc.m_ready = 1'b0;
    write_words(8'h50, 8);
    for (int i = 0; i < 5; i++) tick();
    chk("s5_pre_pops", sc_pops, 2);
    rst = 1'b1;
    #1;
    chk("s5_rd_in_rst", ifc.fifo_rd, 0);
    tick();
    rst = 1'b0;
    expq.delete();
    total_pops = 0;
    sc_pops = 0;
    chk("s5_post_vld", ifc.m_valid, 0);
    chk("s5_post_rd", ifc.fifo_rd, 0);
    chk("s5_post_busy", ifc.busy, 0);
    chk("s5_post_pop_count", ifc.pop_count, 0);
    ifc.m_ready = 1'b1;
    run_until_idle(100);
    chk("s5_drain_pops", sc_pops, 6);
`ifdef FIFO_BURST_READER_STATS_EN
    exp_pc = 32'd6;
`else
    exp_pc = 32'd0;
`endif
    chk("s5_pop_count", ifc.pop_count, exp_pc);

    // Scenario 6: sticky underflow error
    chk("s6_err_before", ifc.err_underflow, 0);
    ifc.fifo_underflow = 1'b1;
    tick();
    ifc.fifo_underflow = 1'b0;
    chk("s6_err_set", ifc.err_underflow, 1);
    for (int i = 0; i < 3; i++) tick();
    chk("s6_err_hold", ifc.err_underflow, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s6_err_clr", ifc.err_underflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
